// File: rtl/bus_generator_arbiter.sv
// Shared-bus arbiter. It pops one packet at a time from the per-device FIFOs in round-robin order
// and delivers it to the destination device, or to every other device for a broadcast.
//
// state | meaning
// IDLE  | waiting for a pending FIFO; arbitrates at each edge
// POP   | pop strobe high for the granted FIFO; head captured at the closing edge
// PUSH  | push strobes high for the routed destinations; D_push carries the packet
module bus_generator_arbiter #(
  parameter int         drvrs     = 8,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [drvrs*pckg_sz-1:0] D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t                   r_state, w_state_nxt;
  // The last grant is also the source of the packet in flight.
  logic [IW-1:0]            r_last, w_last_nxt, w_sel;
  logic                     w_found;
  int                       w_dist, w_best;
  logic [drvrs-1:0]         r_pop, r_push, w_pop_nxt, w_push_nxt, w_route;
  logic [drvrs*pckg_sz-1:0] r_d_push, w_d_push_nxt;
  logic [pckg_sz-1:0]       w_pkt;
  logic [7:0]               w_dst;

  assign pop    = r_pop;
  assign push   = r_push;
  assign D_push = r_d_push;

  // Round-robin: the pending device closest after r_last (distance 1..drvrs) wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_best  = drvrs + 1;
    w_dist  = 0;
    for (int i = 0; i < drvrs; i++) begin
      w_dist = (i > int'(r_last)) ? (i - int'(r_last)) : (i - int'(r_last) + drvrs);
      if (pndng[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_sel   = IW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (r_last == IW'(i)) w_pkt = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign w_dst = w_pkt[pckg_sz-1 -: 8];

  always_comb begin
    w_route = '0;
    if (w_dst == broadcast) begin
      for (int i = 0; i < drvrs; i++) w_route[i] = (r_last != IW'(i));
    end else if ({1'b0, w_dst} < 9'(drvrs)) begin
      for (int i = 0; i < drvrs; i++) w_route[i] = (w_dst == 8'(i));
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_pop_nxt    = '0;
    w_push_nxt   = '0;
    w_d_push_nxt = r_d_push;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_last_nxt  = w_sel;
          w_state_nxt = POP;
          for (int i = 0; i < drvrs; i++) w_pop_nxt[i] = (w_sel == IW'(i));
        end
      end
      POP: begin
        w_push_nxt   = w_route;
        w_d_push_nxt = {drvrs{w_pkt}};
        w_state_nxt  = PUSH;
      end
      PUSH:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= IW'(drvrs - 1);
      r_pop    <= '0;
      r_push   <= '0;
      r_d_push <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_pop    <= w_pop_nxt;
      r_push   <= w_push_nxt;
      r_d_push <= w_d_push_nxt;
    end
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Self-checking bench for bus_generator_arbiter (8 devices, 32-bit packets).
// Expected routing results are queued when stimulus is driven and compared when push fires.
module tb_bus_generator_arbiter;

  localparam int N = 8;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pndng, pop, push;
  logic [N*W-1:0] D_pop, D_push;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] push;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  bus_generator_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [N-1:0] route(input logic [W-1:0] pkt, input int src);
    logic [7:0] dst;
    dst = pkt[W-1 -: 8];
    route = '0;
    if (dst == 8'hFF) begin
      route = '1;
      route[src] = 1'b0;
    end else if (dst < 8'd8) begin
      route[dst[2:0]] = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] mk(input int i, input int seq);
    return {8'((i + 1) % N), 8'(i), 16'(seq)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pndng = '1;
    for (int i = 0; i < N; i++) D_pop[i*W +: W] = {8'(i), 24'(i)};
    repeat (2) begin
      @(negedge clk);
      checks++; if (pop !== '0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pop); end
      checks++; if (push !== '0) begin errors++; $display("FAIL reset_push: got %b expected 0", push); end
      checks++; if (D_push !== '0) begin errors++; $display("FAIL reset_dpush: got %h expected 0", D_push); end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pop !== 8'h01) begin errors++; $display("FAIL reset_first_grant: got %b expected 00000001", pop); end
    pndng = '0;
    @(negedge clk);
    checks++; if (push !== 8'h01) begin errors++; $display("FAIL reset_first_push: got %b expected 00000001", push); end
    @(negedge clk);
  endtask

  task automatic run_single(input int src, input logic [W-1:0] pkt,
                            input logic [N-1:0] exp_push, input string name);
    exp_t e;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[src] = 1'b1;
    @(negedge clk);
    D_pop[src*W +: W] = pkt;
    pndng = onehot;
    @(negedge clk);
    checks++; if (pop !== onehot) begin errors++; $display("FAIL %s_pop: got %b expected %b", name, pop, onehot); end
    sb_q.push_back('{exp_push, pkt});
    pndng = '0;
    @(negedge clk);
    e = sb_q.pop_front();
    checks++; if (push !== e.push) begin errors++; $display("FAIL %s_push: got %b expected %b", name, push, e.push); end
    checks++; if (pop !== '0) begin errors++; $display("FAIL %s_pop_clear: got %b expected 0", name, pop); end
    checks++; if (D_push !== {N{e.data}}) begin errors++; $display("FAIL %s_data: got %h expected %h on all slices", name, D_push, e.data); end
    @(negedge clk);
    checks++; if (push !== '0 || pop !== '0) begin errors++; $display("FAIL %s_idle: got pop=%b push=%b expected both 0", name, pop, push); end
  endtask

  task automatic test_unicast();
    run_single(2, 32'h05ABCDEF, 8'b0010_0000, "unicast");
  endtask

  task automatic test_broadcast();
    run_single(3, 32'hFF123456, 8'b1111_0111, "broadcast");
  endtask

  task automatic test_invalid();
    run_single(1, 32'h09000001, 8'b0000_0000, "invalid");
  endtask

  task automatic test_self_reset();
    run_single(4, 32'h0400AA55, 8'b0001_0000, "self");
    @(negedge clk);
    D_pop[4*W +: W] = 32'h0400AA55;
    pndng = 8'h10;
    @(negedge clk);
    checks++; if (pop !== 8'h10) begin errors++; $display("FAIL midrst_pop: got %b expected 00010000", pop); end
    reset = 1'b1;
    pndng = '0;
    @(negedge clk);
    checks++; if (pop !== '0 || push !== '0) begin errors++; $display("FAIL midrst_strobes: got pop=%b push=%b expected both 0", pop, push); end
    checks++; if (D_push !== '0) begin errors++; $display("FAIL midrst_dpush: got %h expected 0", D_push); end
    reset = 1'b0;
    D_pop[5*W +: W] = 32'h05000005;
    pndng = 8'h30;
    @(negedge clk);
    checks++; if (pop !== 8'h10) begin errors++; $display("FAIL midrst_ptr: got %b expected 00010000", pop); end
    pndng = '0;
    @(negedge clk);
    checks++; if (push !== 8'h10) begin errors++; $display("FAIL midrst_after_push: got %b expected 00010000", push); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cnt[N];
    int rem, grants, last_cyc, g;
    exp_t e;
    logic [W-1:0] head;
    reset = 1'b1;
    pndng = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 2;
      D_pop[i*W +: W] = mk(i, 0);
    end
    pndng = '1;
    rem = -1;
    grants = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 80 && (grants < 2 * N || sb_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (rem >= 0) begin
        cnt[rem]--;
        pndng[rem] = (cnt[rem] > 0);
        if (cnt[rem] > 0) D_pop[rem*W +: W] = mk(rem, 2 - cnt[rem]);
        rem = -1;
      end
      checks++;
      if ($countones(pop) > 1 || (pop != '0 && push != '0)) begin
        errors++; $display("FAIL rr_exclusive: got pop=%b push=%b expected at most one pop bit and no overlap", pop, push);
      end
      if (pop != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (pop[i]) g = i;
        checks++; if (g != grants % N) begin errors++; $display("FAIL rr_order: got device %0d expected %0d", g, grants % N); end
        if (grants > 0) begin
          checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL rr_spacing: got %0d cycles expected 3", cyc - last_cyc); end
        end
        checks++; if (cnt[g] == 0) begin errors++; $display("FAIL rr_empty_pop: got pop on empty device %0d expected none", g); end
        last_cyc = cyc;
        head = mk(g, 2 - cnt[g]);
        sb_q.push_back('{route(head, g), head});
        rem = g;
        grants++;
      end
      if (push != '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rr_unexpected_push: got %b expected no push", push);
        end else begin
          e = sb_q.pop_front();
          if (push !== e.push || D_push !== {N{e.data}}) begin
            errors++; $display("FAIL rr_push: got push=%b data=%h expected push=%b data=%h", push, D_push[W-1:0], e.push, e.data);
          end
        end
      end
    end
    checks++; if (grants != 2 * N) begin errors++; $display("FAIL rr_grant_count: got %0d expected %0d", grants, 2 * N); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d outstanding expected 0", sb_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_invalid();
    test_self_reset();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_generator_arbiter.md
Name: bus_generator_arbiter

Overview:
- Shared-bus model connecting `drvrs` devices; each device owns an external FIFO that exposes a pending flag and head-of-queue data.
- The block arbitrates among pending devices round-robin and pops one packet from the winner.
- It decodes the destination ID from the packet's top byte and pushes the packet into the destination device, or into all other devices for broadcast.
- Sits between the per-device driver FIFOs and the monitors/receivers in the bus testbench environment.

Parameters:
- drvrs, 8, number of devices on the bus (1..254).
- pckg_sz, 32, packet width in bits (>= 9).
- broadcast, 8'hFF, destination ID meaning "all devices except the source".

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- pndng  input  drvrs  bit i high = device i FIFO holds at least one packet.
- D_pop  input  drvrs*pckg_sz  slice i = head packet of device i FIFO; valid whenever pndng[i] is high.
- pop  output  drvrs  one-cycle strobe; FIFO i removes its head at the edge where pop[i] is high.
- push  output  drvrs  one-cycle strobe; device i accepts D_push slice i at the edge where push[i] is high.
- D_push  output  drvrs*pckg_sz  slice i = packet delivered to device i.

Behaviour:
- Packet format: dst = pkt[pckg_sz-1 -: 8]; remaining bits are payload, passed unmodified.
- Reset: at a rising edge with reset high:
  - pop = 0, push = 0, D_push = 0;
  - state = IDLE; round-robin pointer last = drvrs-1, so device 0 has first priority.
  - Reset mid-transaction aborts it; a captured but undelivered packet is lost.
- FSM with three states (IDLE, POP, PUSH), all outputs registered.
- IDLE:
  - If any pndng bit is high, select the first i with pndng[i]=1, searching last+1, last+2, ... with wrap modulo drvrs.
  - Register src=i and set last=i.
  - Drive pop[i]=1 for the next cycle and go to POP. Otherwise stay in IDLE.
- POP:
  - pop[src] is high for exactly this one cycle.
  - At the closing edge, capture pkt = D_pop[src] and clear pop.
  - Go to PUSH, asserting push per the routing rules for the next cycle.
- PUSH:
  - The push bits are high for exactly this one cycle.
  - D_push drives pkt on every slice; slices hold their last value afterwards.
  - Then return to IDLE.
- Routing:
  - dst == broadcast: push[j]=1 for every j != src.
  - dst < drvrs: push[dst]=1, including dst == src.
  - Otherwise: packet is dropped, push stays all-zero, the cycle still elapses.
- Timing:
  - pndng sampled high at edge N gives pop high during cycle N..N+1 and push high during cycle N+1..N+2.
  - A new arbitration happens at the end of the PUSH cycle at the earliest.
  - Maximum throughput is 1 packet per 3 cycles.
- At most one pop bit is ever high, and pop and push are never high in the same cycle.
- pndng changes during POP/PUSH are ignored until the next IDLE.
- An empty FIFO (pndng low) is never popped.
- Fairness: with all devices continuously pending, grants cycle 0,1,...,drvrs-1,0,...

Test Plan:
- Reset: hold reset 2 cycles with pndng=0xFF → pop=0, push=0, D_push=0 during reset; first grant after release is device 0.
- Unicast: device 2 pending with D_pop[2]=32'h05_ABCDEF → pop[2] one cycle later, then push=8'b0010_0000 with D_push[5]=32'h05ABCDEF; no other push bits.
- Broadcast: device 3 sends 32'hFF_123456 → push=8'b1111_0111, all slices carry 32'hFF123456.
- Invalid ID: device 1 sends 32'h09_000001 (drvrs=8) → pop[1] asserted, push stays 0, FSM back to IDLE after 3 cycles.
- Round-robin: pndng=8'hFF held, each FIFO depth 2 → pop order 0,1,...,7,0,...,7 with one grant every 3 cycles, never two pop bits together.
- Self-send and reset mid-op: device 4 sends 32'h04_00AA55 → push[4]; repeat but assert reset during the POP cycle → no push follows, outputs cleared.
